// File: rtl/l23_ctrl_pkg.sv
// l23_ctrl_pkg: shared types, defaults and helpers for the L23 header sequencer.
package l23_ctrl_pkg;

    localparam int unsigned L23_ADDR_W  = 6;
    localparam int unsigned L23_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_WRITE,
        ST_SETREF,
        ST_RESUME,
        ST_ABORT
    } l23_state_e;

    // A header length is legal when it lies in 1..2**addr_w bytes.
    function automatic logic len_is_legal(input int unsigned len, input int unsigned addr_w);
        return (len >= 32'd1) && (len <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/l23_shadow_ram.sv
// l23_shadow_ram: host-side header template store, synchronous write, asynchronous read.
module l23_shadow_ram #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem_q [1 << ADDR_W];

    // Template byte write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Combinational read so a byte is available in the same cycle its address is presented.
    always_comb begin
        rd_data = mem_q[rd_addr];
    end

endmodule

// File: rtl/l23_hdr_sequencer.sv
// l23_hdr_sequencer: stops the L23 buffer, waits for idle, copies the shadow
// template into the header RAM, updates the length reference and restarts it.
module l23_hdr_sequencer
    import l23_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = L23_ADDR_W,
    parameter int unsigned TIMEOUT = L23_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hst_wr_en,
    input  logic [ADDR_W-1:0] hst_wr_addr,
    input  logic [7:0]        hst_wr_data,
    input  logic [ADDR_W:0]   hst_len,
    input  logic              hst_commit,
    input  logic              hst_enable,
    output logic              hst_busy,
    output logic              hst_done,
    output logic              hst_err,
    output logic [ADDR_W-1:0] L23mgmt_refvalue,
    output logic [7:0]        L23mgmt_data,
    output logic [ADDR_W-1:0] L23mgmt_writeaddr,
    output logic              L23mgmt_we,
    output logic              L23mgmt_run,
    input  logic              L23mgmt_idle
);

    localparam int unsigned       CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W:0]   PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    l23_state_e        state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              run_q, run_d;
    logic              we_q, we_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] ref_q, ref_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              host_side;
    logic              len_ok;
    logic              commit_go;
    logic              commit_bad;
    logic              shadow_we;
    logic              copy_last;
    logic [7:0]        rd_data;

    // Host-facing qualifiers. RESUME already presents busy=0/done=1, so it
    // accepts host traffic exactly like IDLE.
    always_comb begin
        host_side  = (state_q == ST_IDLE) || (state_q == ST_RESUME);
        len_ok     = len_is_legal(32'(hst_len), ADDR_W);
        commit_go  = host_side && hst_commit && len_ok;
        commit_bad = host_side && hst_commit && !len_ok;
        shadow_we  = host_side && hst_wr_en;
        copy_last  = (ptr_q == len_q);
    end

    l23_shadow_ram #(
        .ADDR_W (ADDR_W)
    ) u_shadow (
        .clk     (clk),
        .wr_en   (shadow_we),
        .wr_addr (hst_wr_addr),
        .wr_data (hst_wr_data),
        .rd_addr (ptr_q[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_RESUME: state_d = commit_go ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (L23mgmt_idle) begin
                    state_d = ST_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ABORT;
                end
            end
            ST_WRITE:  state_d = copy_last ? ST_SETREF : ST_WRITE;
            ST_SETREF: state_d = ST_RESUME;
            ST_ABORT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Registered outputs and datapath, computed from the transition being taken.
    always_comb begin
        run_d   = run_q;
        we_d    = 1'b0;
        data_d  = data_q;
        waddr_d = waddr_q;
        ref_d   = ref_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_RESUME: begin
                run_d  = hst_enable;
                busy_d = 1'b0;
                if (commit_go) begin
                    len_d  = hst_len;
                    ptr_d  = '0;
                    cnt_d  = '0;
                    run_d  = 1'b0;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                end else if (commit_bad) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                run_d  = 1'b0;
                busy_d = 1'b1;
                if (L23mgmt_idle) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q[ADDR_W-1:0];
                    data_d  = rd_data;
                    ptr_d   = ptr_q + PTR_ONE;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WRITE: begin
                run_d  = 1'b0;
                busy_d = 1'b1;
                if (copy_last) begin
                    ref_d = ADDR_W'(len_q - PTR_ONE);
                end else begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q[ADDR_W-1:0];
                    data_d  = rd_data;
                    ptr_d   = ptr_q + PTR_ONE;
                end
            end
            ST_SETREF: begin
                run_d  = hst_enable;
                busy_d = 1'b0;
                done_d = 1'b1;
                err_d  = 1'b0;
            end
            ST_ABORT: begin
                run_d  = hst_enable;
                busy_d = 1'b0;
                done_d = 1'b1;
                err_d  = 1'b1;
            end
            default: begin
                run_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q   <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= '0;
            waddr_q <= '0;
            ref_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            run_q   <= run_d;
            we_q    <= we_d;
            data_q  <= data_d;
            waddr_q <= waddr_d;
            ref_q   <= ref_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hst_busy          = busy_q;
    assign hst_done          = done_q;
    assign hst_err           = err_q;
    assign L23mgmt_refvalue  = ref_q;
    assign L23mgmt_data      = data_q;
    assign L23mgmt_writeaddr = waddr_q;
    assign L23mgmt_we        = we_q;
    assign L23mgmt_run       = run_q;

endmodule

// File: tb/tb_l23_hdr_sequencer.sv
// tb_l23_hdr_sequencer: randomized scoreboard bench for the L23 header sequencer.
module tb_l23_hdr_sequencer;

    localparam int unsigned AW   = 6;
    localparam int unsigned TO   = 16;
    localparam int unsigned HMAX = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hst_wr_en = 1'b0;
    logic [AW-1:0] hst_wr_addr = '0;
    logic [7:0]    hst_wr_data = '0;
    logic [AW:0]   hst_len = '0;
    logic          hst_commit = 1'b0;
    logic          hst_enable = 1'b0;
    logic          hst_busy;
    logic          hst_done;
    logic          hst_err;
    logic [AW-1:0] L23mgmt_refvalue;
    logic [7:0]    L23mgmt_data;
    logic [AW-1:0] L23mgmt_writeaddr;
    logic          L23mgmt_we;
    logic          L23mgmt_run;
    logic          L23mgmt_idle = 1'b1;

    l23_hdr_sequencer #(
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .hst_wr_en         (hst_wr_en),
        .hst_wr_addr       (hst_wr_addr),
        .hst_wr_data       (hst_wr_data),
        .hst_len           (hst_len),
        .hst_commit        (hst_commit),
        .hst_enable        (hst_enable),
        .hst_busy          (hst_busy),
        .hst_done          (hst_done),
        .hst_err           (hst_err),
        .L23mgmt_refvalue  (L23mgmt_refvalue),
        .L23mgmt_data      (L23mgmt_data),
        .L23mgmt_writeaddr (L23mgmt_writeaddr),
        .L23mgmt_we        (L23mgmt_we),
        .L23mgmt_run       (L23mgmt_run),
        .L23mgmt_idle      (L23mgmt_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cyc;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct {
        int unsigned   cyc;
        logic          err;
        logic [AW-1:0] rv;
    } done_t;

    wr_t         wr_q[$];
    done_t       done_q[$];
    logic [7:0]  shadow_m [HMAX];
    logic [AW-1:0] ref_m = '0;

    // Busy window [win_lo, win_hi]; host inputs are ignored on edges act_c+1..act_d.
    int unsigned cyc = 0;
    int unsigned win_lo = 1, win_hi = 0;
    int unsigned act_c = 0, act_d = 0;
    int unsigned checks = 0, errors = 0;
    logic        en_smp = 1'b0, rst_smp = 1'b0;

    // Edge counter and the host inputs as seen at each edge.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        en_smp  <= hst_enable;
        rst_smp <= rst;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard queues.
    always @(negedge clk) begin
        logic  in_win, exp_we, exp_done;
        wr_t   w;
        done_t d;
        if (rst_smp) begin
            chk("reset_outputs",
                64'({L23mgmt_run, L23mgmt_we, L23mgmt_data, L23mgmt_writeaddr,
                     L23mgmt_refvalue, hst_busy, hst_done, hst_err}), 64'(0));
        end else begin
            in_win = (cyc >= win_lo) && (cyc <= win_hi);
            chk("busy", 64'(hst_busy), 64'(in_win));
            chk("run", 64'(L23mgmt_run), 64'(in_win ? 1'b0 : en_smp));
            exp_we = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
            chk("we", 64'(L23mgmt_we), 64'(exp_we));
            if (exp_we) begin
                w = wr_q.pop_front();
                chk("wr_addr", 64'(L23mgmt_writeaddr), 64'(w.addr));
                chk("wr_data", 64'(L23mgmt_data), 64'(w.data));
            end
            exp_done = (done_q.size() > 0) && (done_q[0].cyc == cyc);
            chk("done", 64'(hst_done), 64'(exp_done));
            if (exp_done) begin
                d = done_q.pop_front();
                chk("done_err", 64'(hst_err), 64'(d.err));
                chk("done_refvalue", 64'(L23mgmt_refvalue), 64'(d.rv));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic bit blocked(input int unsigned e);
        return (e > act_c) && (e <= act_d);
    endfunction

    // Reference model: the whole expected response of one accepted commit.
    task automatic model_commit(input int unsigned c, input int unsigned len, input int unsigned w);
        int unsigned d;
        if (len < 1 || len > HMAX) begin
            done_q.push_back('{cyc: c, err: 1'b1, rv: ref_m});
            return;
        end
        if (w >= TO) begin
            d = c + TO + 1;
        end else begin
            for (int unsigned i = 0; i < len; i++)
                wr_q.push_back('{cyc: c + w + 1 + i, addr: AW'(i), data: shadow_m[i]});
            d = c + w + len + 2;
            ref_m = AW'(len - 1);
        end
        done_q.push_back('{cyc: d, err: 1'(w >= TO), rv: ref_m});
        act_c  = c;
        act_d  = d;
        win_lo = c;
        win_hi = d - 1;
    endtask

    task automatic host_write(input int unsigned a, input logic [7:0] d);
        hst_wr_en   = 1'b1;
        hst_wr_addr = AW'(a);
        hst_wr_data = d;
        if (!blocked(cyc + 1)) shadow_m[a] = d;
        tick();
        hst_wr_en = 1'b0;
    endtask

    // Commit with the buffer reporting busy for w cycles before going idle.
    task automatic commit(input int unsigned len, input int unsigned w);
        int unsigned c;
        c = cyc + 1;
        hst_commit = 1'b1;
        hst_len    = (AW + 1)'(len);
        if (w > 0) L23mgmt_idle = 1'b0;
        if (!blocked(c)) model_commit(c, len, w);
        tick();
        hst_commit = 1'b0;
        hst_len    = (AW + 1)'($urandom);
        repeat (w) tick();
        L23mgmt_idle = 1'b1;
    endtask

    task automatic wait_done();
        while (cyc <= act_d) begin
            if ($urandom_range(0, 3) == 0) hst_enable = 1'($urandom);
            tick();
        end
    endtask

    task automatic reset_pulse();
        int unsigned r;
        r = cyc + 1;
        rst = 1'b1;
        while (wr_q.size() > 0 && wr_q[$].cyc >= r) void'(wr_q.pop_back());
        while (done_q.size() > 0 && done_q[$].cyc >= r) void'(done_q.pop_back());
        if (win_hi >= r) win_hi = r - 1;
        if (act_d >= r) act_d = r - 1;
        ref_m = '0;
        tick();
        rst = 1'b0;
    endtask

    // Driver: directed scenarios followed by randomized commits.
    initial begin
        repeat (3) tick();
        rst = 1'b0;
        for (int unsigned i = 0; i < HMAX; i++) host_write(i, 8'($urandom));

        hst_enable = 1'b1;
        host_write(0, 8'h40);
        host_write(1, 8'h80);
        host_write(2, 8'hC0);
        commit(3, 0);
        wait_done();

        commit(3, TO - 1);
        wait_done();
        commit(3, 20);
        wait_done();

        commit(1, 0);
        wait_done();
        commit(HMAX, 0);
        wait_done();
        commit(0, 0);
        commit(HMAX + 1, 0);
        tick();

        commit(8, 0);
        tick();
        hst_commit  = 1'b1;
        hst_len     = (AW + 1)'(2);
        hst_wr_en   = 1'b1;
        hst_wr_addr = AW'(1);
        hst_wr_data = ~shadow_m[1];
        if (!blocked(cyc + 1)) begin
            shadow_m[1] = hst_wr_data;
            model_commit(cyc + 1, 2, 0);
        end
        tick();
        hst_commit = 1'b0;
        hst_wr_en  = 1'b0;
        wait_done();
        commit(3, 0);
        wait_done();

        commit(10, 0);
        tick();
        tick();
        reset_pulse();
        tick();
        commit(5, 2);
        wait_done();

        for (int k = 0; k < 40; k++) begin
            int unsigned nw, len, w;
            nw = $urandom_range(0, 4);
            for (int j = 0; j < int'(nw); j++)
                host_write($urandom_range(0, HMAX - 1), 8'($urandom));
            hst_enable = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = $urandom_range(HMAX + 1, 2 * HMAX - 1);
                default: len = $urandom_range(1, HMAX);
            endcase
            w = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, TO - 1);
            commit(len, w);
            wait_done();
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (4) tick();
        chk("queues_drained", 64'(wr_q.size() + done_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
